// File: rtl/multicycle_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : multicycle_ctrl                                            |
// | Description : Multi-cycle control FSM for the MIPS-lite core; sequences  |
// |               fetch/decode/execute/memory/writeback and drives datapath  |
// |               mux selects and write enables.                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module multicycle_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       ir_wr,
    output logic       pc_wr,
    output logic [1:0] pc_sel,
    output logic [1:0] RegDst,
    output logic [1:0] ALUSrc,
    output logic [1:0] DatatoReg,
    output logic [1:0] ext_op,
    output logic [2:0] alu_op,
    output logic       reg_wr,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       instr_done,
    output logic       illegal,
    output logic       bus_err,
    output logic [3:0] state
);

    localparam logic [3:0] c_FETCH  = 4'd0;
    localparam logic [3:0] c_DECODE = 4'd1;
    localparam logic [3:0] c_EXEC   = 4'd2;
    localparam logic [3:0] c_MEM_RD = 4'd3;
    localparam logic [3:0] c_MEM_WR = 4'd4;
    localparam logic [3:0] c_WB     = 4'd5;
    localparam logic [3:0] c_BRANCH = 4'd6;
    localparam logic [3:0] c_JUMP   = 4'd7;
    localparam logic [3:0] c_HALT   = 4'd8;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_LUI   = 6'h0F;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    localparam logic [5:0] c_FN_SLL  = 6'h00;
    localparam logic [5:0] c_FN_SRL  = 6'h02;
    localparam logic [5:0] c_FN_JR   = 6'h08;
    localparam logic [5:0] c_FN_ADDU = 6'h21;
    localparam logic [5:0] c_FN_SUBU = 6'h23;

    // A wait state gives up once it has spent TIMEOUT cycles with mem_ready low.
    localparam logic [7:0] c_WAIT_LIMIT = 8'(TIMEOUT - 1);

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    logic [7:0] r_wait_cnt;
    logic       r_illegal;
    logic       r_bus_err;
    logic       w_set_illegal;
    logic       w_set_bus_err;
    logic       w_timeout;
    logic       w_waiting;
    logic       w_r_alu;
    logic       w_ir_wr;
    logic       w_pc_wr;
    logic       w_reg_wr;
    logic       w_mem_wr;
    logic       w_instr_done;

    assign w_r_alu   = (op == c_OP_RTYPE) &&
                       ((funct == c_FN_ADDU) || (funct == c_FN_SUBU) ||
                        (funct == c_FN_SLL)  || (funct == c_FN_SRL));
    assign w_timeout = !mem_ready && (r_wait_cnt >= c_WAIT_LIMIT);
    assign w_waiting = (r_state == c_FETCH) || (r_state == c_MEM_RD) || (r_state == c_MEM_WR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_FETCH;
            r_wait_cnt <= 8'd0;
            r_illegal  <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_next_state != r_state) begin
                r_wait_cnt <= 8'd0;
            end else if (w_waiting) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
            if (w_set_bus_err) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_set_illegal = 1'b0;
        w_set_bus_err = 1'b0;
        w_ir_wr       = 1'b0;
        w_pc_wr       = 1'b0;
        w_reg_wr      = 1'b0;
        w_mem_wr      = 1'b0;
        w_instr_done  = 1'b0;
        pc_sel        = 2'b00;
        RegDst        = 2'b00;
        ALUSrc        = 2'b00;
        DatatoReg     = 2'b00;
        ext_op        = 2'b00;
        alu_op        = 3'b000;
        mem_rd        = 1'b0;
        case (r_state)
            c_FETCH: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    w_ir_wr      = 1'b1;
                    w_pc_wr      = 1'b1;
                    w_next_state = c_DECODE;
                end else if (w_timeout) begin
                    w_next_state  = c_HALT;
                    w_set_bus_err = 1'b1;
                end
            end
            c_DECODE: begin
                if (w_r_alu || (op == c_OP_ORI) || (op == c_OP_LUI) ||
                    (op == c_OP_LW) || (op == c_OP_SW)) begin
                    w_next_state = c_EXEC;
                end else if (op == c_OP_BEQ) begin
                    w_next_state = c_BRANCH;
                end else if ((op == c_OP_J) || (op == c_OP_JAL) ||
                             ((op == c_OP_RTYPE) && (funct == c_FN_JR))) begin
                    w_next_state = c_JUMP;
                end else begin
                    w_next_state  = c_HALT;
                    w_set_illegal = 1'b1;
                end
            end
            c_EXEC: begin
                w_next_state = c_WB;
                case (op)
                    c_OP_RTYPE: begin
                        case (funct)
                            c_FN_SUBU: alu_op = 3'b001;
                            c_FN_SLL: begin
                                alu_op = 3'b011;
                                ALUSrc = 2'b10;
                            end
                            c_FN_SRL: begin
                                alu_op = 3'b100;
                                ALUSrc = 2'b10;
                            end
                            default: alu_op = 3'b000;
                        endcase
                    end
                    c_OP_ORI: begin
                        alu_op = 3'b010;
                        ALUSrc = 2'b01;
                    end
                    c_OP_LUI: begin
                        ALUSrc = 2'b01;
                        ext_op = 2'b10;
                    end
                    c_OP_LW: begin
                        ALUSrc       = 2'b01;
                        ext_op       = 2'b01;
                        w_next_state = c_MEM_RD;
                    end
                    c_OP_SW: begin
                        ALUSrc       = 2'b01;
                        ext_op       = 2'b01;
                        w_next_state = c_MEM_WR;
                    end
                    default: w_next_state = c_WB;
                endcase
            end
            c_MEM_RD: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    w_next_state = c_WB;
                end else if (w_timeout) begin
                    w_next_state  = c_HALT;
                    w_set_bus_err = 1'b1;
                end
            end
            c_MEM_WR: begin
                w_mem_wr = 1'b1;
                if (mem_ready) begin
                    w_instr_done = 1'b1;
                    w_next_state = c_FETCH;
                end else if (w_timeout) begin
                    w_next_state  = c_HALT;
                    w_set_bus_err = 1'b1;
                end
            end
            c_WB: begin
                w_reg_wr     = 1'b1;
                RegDst       = (op == c_OP_RTYPE) ? 2'b01 : 2'b00;
                DatatoReg    = (op == c_OP_LW) ? 2'b01 : 2'b00;
                w_instr_done = 1'b1;
                w_next_state = c_FETCH;
            end
            c_BRANCH: begin
                alu_op       = 3'b001;
                w_pc_wr      = zero;
                pc_sel       = 2'b01;
                w_instr_done = 1'b1;
                w_next_state = c_FETCH;
            end
            c_JUMP: begin
                w_pc_wr      = 1'b1;
                w_instr_done = 1'b1;
                w_next_state = c_FETCH;
                case (op)
                    c_OP_J: pc_sel = 2'b10;
                    c_OP_JAL: begin
                        pc_sel    = 2'b10;
                        w_reg_wr  = 1'b1;
                        RegDst    = 2'b10;
                        DatatoReg = 2'b10;
                    end
                    default: pc_sel = 2'b11;
                endcase
            end
            c_HALT: w_next_state = c_HALT;
            default: w_next_state = c_HALT;
        endcase
    end

    // Enables are masked while reset is held so an abandoned access cannot commit.
    assign ir_wr      = w_ir_wr      & ~reset;
    assign pc_wr      = w_pc_wr      & ~reset;
    assign reg_wr     = w_reg_wr     & ~reset;
    assign mem_wr     = w_mem_wr     & ~reset;
    assign instr_done = w_instr_done & ~reset;
    assign illegal    = r_illegal;
    assign bus_err    = r_bus_err;
    assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_multicycle_ctrl                                         |
// | Description : Scoreboard bench for multicycle_ctrl with a reactive       |
// |               memory responder and an instruction-level reference model. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_multicycle_ctrl;

    localparam int TIMEOUT = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       ir_wr, pc_wr, reg_wr, mem_rd, mem_wr, instr_done, illegal, bus_err;
    logic [1:0] pc_sel, RegDst, ALUSrc, DatatoReg, ext_op;
    logic [2:0] alu_op;
    logic [3:0] state;

    multicycle_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_sel(pc_sel),
        .RegDst(RegDst), .ALUSrc(ALUSrc), .DatatoReg(DatatoReg), .ext_op(ext_op),
        .alu_op(alu_op), .reg_wr(reg_wr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .instr_done(instr_done), .illegal(illegal), .bus_err(bus_err), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          len;
        logic [31:0] path;
        int          rd_cyc, wr_cyc, ir_cnt, pc_cnt, rw_cnt;
        int          alu, src, ext;
        int          fin_sel, fin_dst, fin_d2r, fin_alu;
    } exp_t;

    typedef struct {
        string name;
        int    sig;
        int    exp;
    } pchk_t;

    exp_t  sb[$];
    pchk_t pq[$];
    int    plan[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    n_expired = 0;

    // Instruction classes used by the reference model.
    localparam int K_ADDU = 0, K_SUBU = 1, K_SLL = 2, K_SRL = 3, K_ORI = 4, K_LUI = 5;
    localparam int K_LW = 6, K_SW = 7, K_BEQ = 8, K_J = 9, K_JAL = 10, K_JR = 11, K_BAD = 12;

    function automatic int kind_of(input logic [5:0] o, input logic [5:0] f);
        if (o == 6'h00) begin
            case (f)
                6'h21: return K_ADDU;
                6'h23: return K_SUBU;
                6'h00: return K_SLL;
                6'h02: return K_SRL;
                6'h08: return K_JR;
                default: return K_BAD;
            endcase
        end
        case (o)
            6'h0D: return K_ORI;
            6'h0F: return K_LUI;
            6'h23: return K_LW;
            6'h2B: return K_SW;
            6'h04: return K_BEQ;
            6'h02: return K_J;
            6'h03: return K_JAL;
            default: return K_BAD;
        endcase
    endfunction

    // Expected whole-instruction behaviour; fs/ms are fetch and data-access stall cycles.
    function automatic exp_t model(input logic [5:0] o, input logic [5:0] f, input logic z,
                                   input int fs, input int ms);
        exp_t e;
        int   k;
        k = kind_of(o, f);
        e = '{default: 0};
        e.ir_cnt = 1;
        e.pc_cnt = 1;
        e.rd_cyc = 1 + fs;
        case (k)
            K_ADDU, K_SUBU, K_SLL, K_SRL, K_ORI, K_LUI: begin
                e.len = 4 + fs; e.path = 32'h0125; e.rw_cnt = 1;
            end
            K_LW: begin
                e.len = 5 + fs + ms; e.path = 32'h01235; e.rw_cnt = 1;
                e.rd_cyc = e.rd_cyc + 1 + ms; e.fin_d2r = 1;
            end
            K_SW: begin
                e.len = 4 + fs + ms; e.path = 32'h0124; e.wr_cyc = 1 + ms;
            end
            K_BEQ: begin
                e.len = 3 + fs; e.path = 32'h016; e.pc_cnt = 1 + int'(z);
                e.fin_sel = 1; e.fin_alu = 1;
            end
            default: begin
                e.len = 3 + fs; e.path = 32'h017; e.pc_cnt = 2;
                e.fin_sel = (k == K_JR) ? 3 : 2;
                if (k == K_JAL) begin
                    e.rw_cnt = 1; e.fin_dst = 2; e.fin_d2r = 2;
                end
            end
        endcase
        if (k <= K_SRL) e.fin_dst = 1;
        case (k)
            K_SUBU: e.alu = 1;
            K_SLL:  begin e.alu = 3; e.src = 2; end
            K_SRL:  begin e.alu = 4; e.src = 2; end
            K_ORI:  begin e.alu = 2; e.src = 1; end
            K_LUI:  begin e.src = 1; e.ext = 2; end
            K_LW, K_SW: begin e.src = 1; e.ext = 1; end
            default: e.alu = 0;
        endcase
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int sig_val(input int id);
        case (id)
            0: return int'(state);
            1: return int'(illegal);
            2: return int'(bus_err);
            3: return int'(ir_wr | pc_wr | reg_wr | mem_wr | instr_done);
            4: return int'(mem_wr);
            5: return int'(mem_rd);
            6: return sb.size();
            default: return n_expired;
        endcase
    endfunction

    task automatic pchk(input string n, input int s, input int e);
        pchk_t p;
        p.name = n; p.sig = s; p.exp = e;
        pq.push_back(p);
    endtask

    // Memory responder: each strobe-held access consumes one stall count from the plan.
    int stall_left = 0;
    bit in_acc = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            in_acc = 1'b0;
            mem_ready = 1'b1;
        end else if (mem_rd || mem_wr) begin
            if (!in_acc) begin
                in_acc = 1'b1;
                stall_left = (plan.size() > 0) ? plan.pop_front() : 0;
            end
            if (stall_left > 0) begin
                mem_ready = 1'b0;
                stall_left--;
            end else begin
                mem_ready = 1'b1;
                in_acc = 1'b0;
            end
        end else begin
            in_acc = 1'b0;
            mem_ready = 1'($urandom);
        end
    end

    // Monitor: per-instruction observation compared against the scoreboard at instr_done.
    int          cyc = 0, rd_c = 0, wr_c = 0, ir_c = 0, pc_c = 0, rw_c = 0;
    int          cap_alu = 0, cap_src = 0, cap_ext = 0;
    logic [31:0] trace = 32'd0;
    logic [3:0]  last_st = 4'd0;
    always @(negedge clk) begin : mon
        pchk_t p;
        exp_t  e;
        #1;
        while (pq.size() > 0) begin
            p = pq.pop_front();
            check(p.name, sig_val(p.sig), p.exp);
        end
        if (reset) begin
            cyc = 0; rd_c = 0; wr_c = 0; ir_c = 0; pc_c = 0; rw_c = 0;
            cap_alu = 0; cap_src = 0; cap_ext = 0;
        end else begin
            if (cyc == 0) trace = {28'd0, state};
            else if (state != last_st) trace = {trace[27:0], state};
            last_st = state;
            cyc++;
            rd_c += int'(mem_rd); wr_c += int'(mem_wr); ir_c += int'(ir_wr);
            pc_c += int'(pc_wr); rw_c += int'(reg_wr);
            if (state == 4'd2) begin
                cap_alu = int'(alu_op); cap_src = int'(ALUSrc); cap_ext = int'(ext_op);
            end
            if (instr_done) begin
                if (sb.size() == 0) begin
                    check("done_without_expected", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check("latency", cyc, e.len);
                    check("state_path", int'(trace), int'(e.path));
                    check("mem_rd_cycles", rd_c, e.rd_cyc);
                    check("mem_wr_cycles", wr_c, e.wr_cyc);
                    check("ir_wr_count", ir_c, e.ir_cnt);
                    check("pc_wr_count", pc_c, e.pc_cnt);
                    check("reg_wr_count", rw_c, e.rw_cnt);
                    check("exec_alu_op", cap_alu, e.alu);
                    check("exec_ALUSrc", cap_src, e.src);
                    check("exec_ext_op", cap_ext, e.ext);
                    check("final_pc_sel", int'(pc_sel), e.fin_sel);
                    check("final_RegDst", int'(RegDst), e.fin_dst);
                    check("final_DatatoReg", int'(DatatoReg), e.fin_d2r);
                    check("final_alu_op", int'(alu_op), e.fin_alu);
                end
                cyc = 0; rd_c = 0; wr_c = 0; ir_c = 0; pc_c = 0; rw_c = 0;
                cap_alu = 0; cap_src = 0; cap_ext = 0;
            end
        end
    end

    // Called just after a rising edge with the DUT in FETCH; returns the same way.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input int fs, input int ms);
        bit seen;
        int k;
        op = o; funct = f; zero = z;
        k = kind_of(o, f);
        plan.push_back(fs);
        if (k == K_LW || k == K_SW) plan.push_back(ms);
        sb.push_back(model(o, f, z, fs, ms));
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk); #2;
            if (instr_done) seen = 1'b1;
        end
        if (!seen) n_expired++;
        @(posedge clk); #1;
    endtask

    logic [5:0] t_op [12] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h0D,
                              6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03};
    logic [5:0] t_fn [12] = '{6'h21, 6'h23, 6'h00, 6'h02, 6'h08, 6'h00,
                              6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

    initial begin
        int idx;
        logic [5:0] fsel;
        repeat (2) @(posedge clk);
        #1;
        pchk("rst_state", 0, 0);
        pchk("rst_illegal", 1, 0);
        pchk("rst_bus_err", 2, 0);
        pchk("rst_enables", 3, 0);
        pchk("rst_mem_rd", 5, 1);
        @(posedge clk); #1;
        reset = 1'b0;

        run_instr(6'h00, 6'h21, 1'b0, 0, 0);              // addu
        run_instr(6'h23, 6'h15, 1'b0, 0, 3);              // lw, data stall at the limit
        run_instr(6'h04, 6'h00, 1'b1, 0, 0);              // beq taken
        run_instr(6'h04, 6'h00, 1'b0, 0, 0);              // beq not taken
        run_instr(6'h03, 6'h2A, 1'b0, 0, 0);              // jal
        run_instr(6'h2B, 6'h00, 1'b0, 3, TIMEOUT - 1);    // sw, both stalls at the limit

        for (int n = 0; n < 60; n++) begin
            idx = $urandom_range(0, 11);
            fsel = (t_op[idx] == 6'h00) ? t_fn[idx] : 6'($urandom);
            run_instr(t_op[idx], fsel, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Unsupported opcode: halt with illegal flagged, inert until reset.
        op = 6'h3F; funct = 6'($urandom);
        plan.push_back(0);
        repeat (2) begin @(posedge clk); #1; end
        pchk("ill_flag", 1, 1);
        pchk("ill_no_bus_err", 2, 0);
        for (int c = 0; c < 20; c++) begin
            pchk("ill_halt_state", 0, 8);
            pchk("ill_halt_enables", 3, 0);
            pchk("ill_halt_mem_rd", 5, 0);
            @(posedge clk); #1;
        end
        reset = 1'b1;
        pchk("ill_rst_state", 0, 0);
        pchk("ill_rst_flag", 1, 0);
        pchk("ill_rst_enables", 3, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // sw whose write never completes: TIMEOUT wait cycles then HALT with bus_err.
        op = 6'h2B; funct = 6'($urandom);
        plan.push_back(0); plan.push_back(20);
        for (int c = 0; c <= 3 + TIMEOUT; c++) begin
            if (c == 3) pchk("to_bus_err_early", 2, 0);
            if (c >= 3 && c < 3 + TIMEOUT) begin
                pchk("to_wait_state", 0, 4);
                pchk("to_mem_wr_held", 4, 1);
            end
            if (c == 3 + TIMEOUT) begin
                pchk("to_halt_state", 0, 8);
                pchk("to_bus_err", 2, 1);
                pchk("to_halt_enables", 3, 0);
            end
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        pchk("to_rst_bus_err", 2, 0);

        // Reset in the middle of a stalled store drops mem_wr immediately.
        op = 6'h2B; funct = 6'h00;
        plan.push_back(0); plan.push_back(2);
        for (int c = 0; c < 5; c++) begin
            if (c >= 3) begin
                pchk("mid_wr_state", 0, 4);
                pchk("mid_wr_mem_wr", 4, 1);
            end
            @(posedge clk); #1;
        end
        reset = 1'b1;
        pchk("mid_rst_mem_wr", 4, 0);
        pchk("mid_rst_state", 0, 0);
        pchk("mid_rst_enables", 3, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_instr(6'h00, 6'h23, 1'b0, 1, 0);              // subu after recovery

        pchk("scoreboard_drained", 6, 0);
        pchk("bounded_waits_expired", 7, 0);
        @(negedge clk); #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
